// File: rtl/bram_stream_reader_if.sv
// BRAM port-B read bus plus the outgoing valid/ready word stream of bram_stream_reader.
// The reader is the master: it drives the BRAM strobe/address and the stream outputs.
interface bram_stream_reader_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output bram_en, bram_addr, m_data, m_valid, m_last,
    input  bram_dout, m_ready
  );

  modport slave (
    input  bram_en, bram_addr, m_data, m_valid, m_last,
    output bram_dout, m_ready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Reads a contiguous, wrapping window of BRAM words through port B and streams them out via
// a 2-entry FIFO, accumulating an additive checksum and pulsing done after the last handshake.
module bram_stream_reader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum,
  bram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [ADDR_W:0] CntOne = 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]     pop_cnt_q, pop_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic [DATA_W-1:0]   fifo_q [2];
  logic [DATA_W-1:0]   fifo_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic                pop;
  logic                issue;
  logic                last_head;
  logic [2:0]          occ;
  logic [ADDR_W-1:0]   issue_addr;
  logic [DATA_W-1:0]   head;

  // Issue gating and stream outputs; bram_en is decided in the cycle it is asserted.
  always_comb begin
    head       = fifo_q[rd_ptr_q];
    pop        = (count_q != 2'd0) && bus.m_ready;
    last_head  = (pop_cnt_q == (len_q - CntOne));
    // Words already buffered plus the read whose data lands this cycle.
    occ        = {1'b0, count_q} + {2'b00, pend_q};
    issue      = (state_q == StRun) && (issue_cnt_q != len_q) &&
                 (pop ? (occ < 3'd3) : (occ < 3'd2));
    issue_addr = base_q + issue_cnt_q[ADDR_W-1:0];

    bus.bram_en   = issue;
    bus.bram_addr = issue ? issue_addr : addr_q;
    bus.m_valid   = (count_q != 2'd0);
    bus.m_data    = head;
    bus.m_last    = (count_q != 2'd0) && last_head;
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    checksum      = checksum_q;
  end

  // Transfer control: counters, checksum and state transitions.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    checksum_d  = checksum_q;
    addr_d      = addr_q;
    pend_d      = issue;

    if (issue) begin
      issue_cnt_d = issue_cnt_q + CntOne;
      addr_d      = issue_addr;
    end
    if (pop) begin
      pop_cnt_d  = pop_cnt_q + CntOne;
      checksum_d = checksum_q + head;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d      = base_addr;
          len_d       = length;
          issue_cnt_d = '0;
          pop_cnt_d   = '0;
          checksum_d  = '0;
          state_d     = (length == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue && (issue_cnt_q == (len_q - CntOne))) state_d = StDrain;
      end
      StDrain: begin
        if (pop && last_head) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  // Two-entry output FIFO: push read data one cycle after its strobe, pop on handshake.
  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (pend_q) begin
      fifo_d[wr_ptr_q] = bus.bram_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    unique case ({pend_q, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards any in-flight read and empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      checksum_q  <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      checksum_q  <= checksum_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a 1-cycle-latency BRAM model, a queue-based model of
// the expected word stream, a per-cycle compare process and literal checks per scenario.
module tb_bram_stream_reader;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done;
  logic [DW-1:0] checksum;

  bram_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // BRAM port B: registered read, data valid the cycle after bram_en.
  logic [DW-1:0] mem [NW];
  always @(posedge clk) if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // m_ready: mode 0 always high, mode 1 repeats 1,0,0,1.
  int ready_mode = 0;
  int phase = 0;
  initial bus.m_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.m_ready = (ready_mode == 0) ? 1'b1 : ((phase % 4 == 0) || (phase % 4 == 3));
    phase++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected-behaviour model of the current transfer.
  logic [DW-1:0] exp_q [$];
  int            len_m, base_m, issued, popped, start_cyc;
  logic [DW-1:0] sum_m;
  bit            active = 1'b0;
  bit            finished;
  int            first_en, last_en, first_valid, done_rel, done_cnt;
  int            addr_log [$];
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  bit            prev_last;

  // Compare process: checks the DUT against the model on every cycle of a transfer.
  always @(negedge clk) begin
    if (rst && active) begin
      int rel;
      rel = cyc - start_cyc;
      chk("checksum_track", checksum, sum_m);
      chk("busy", busy, !finished);
      if (finished) chk("done_once", done, 1'b0);
      if (bus.bram_en) begin
        if (first_en < 0) first_en = rel;
        last_en = rel;
        addr_log.push_back(int'(bus.bram_addr));
        chk("bram_addr", bus.bram_addr, (base_m + issued) % NW);
        chk("read_in_window", issued < len_m, 1'b1);
        issued++;
      end
      if (bus.m_valid) begin
        if (first_valid < 0) first_valid = rel;
        if (prev_stall) begin
          chk("stall_data", bus.m_data, prev_data);
          chk("stall_last", bus.m_last, prev_last);
        end
        if (exp_q.size() == 0) chk("spurious_valid", bus.m_valid, 1'b0);
        else begin
          chk("m_data", bus.m_data, exp_q[0]);
          chk("m_last", bus.m_last, exp_q.size() == 1);
          if (bus.m_ready) begin
            sum_m = sum_m + exp_q.pop_front();
            popped++;
          end
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      chk("occupancy", (issued - popped) <= 2, 1'b1);
      if (done && !finished) begin
        done_rel = rel;
        done_cnt++;
        chk("done_all_words", exp_q.size(), 0);
        finished = 1'b1;
      end
    end
  end

  task automatic begin_xfer(input int b, input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    length = (AW + 1)'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % NW]);
    len_m = n; base_m = b; issued = 0; popped = 0; sum_m = '0;
    first_en = -1; last_en = -1; first_valid = -1; done_rel = -1; done_cnt = 0;
    addr_log.delete();
    prev_stall = 1'b0;
    finished = 1'b0;
    start_cyc = cyc - 1;
    active = 1'b1;
  endtask

  task automatic wait_finish(input bit midstart);
    for (int i = 0; i < 4000 && !finished; i++) begin
      @(posedge clk);
      #1;
      start = midstart && (i == 5);
      base_addr = midstart && (i == 5) ? AW'(11'h123) : base_addr;
      length = midstart && (i == 5) ? (AW + 1)'(7) : length;
    end
    start = 1'b0;
    if (!finished) chk("done_timeout", 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    active = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_checksum"}, checksum, '0);
    chk({tag, "_bram_en"}, bus.bram_en, 1'b0);
    chk({tag, "_bram_addr"}, bus.bram_addr, '0);
    chk({tag, "_m_data"}, bus.m_data, '0);
    chk({tag, "_m_valid"}, bus.m_valid, 1'b0);
    chk({tag, "_m_last"}, bus.m_last, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = DW'(i);
    #1;
    chk_all_zero("reset");
    #20;
    rst = 1'b1;

    // Basic 4-word read from address 0.
    ready_mode = 0;
    begin_xfer(0, 4);
    wait_finish(1'b0);
    chk("t1_first_en", first_en, 1);
    chk("t1_last_en", last_en, 4);
    chk("t1_first_valid", first_valid, 3);
    chk("t1_done_cycle", done_rel, 7);
    chk("t1_checksum", checksum, 32'd6);

    // Address wrap at the top of the memory.
    begin_xfer(11'h7fe, 4);
    wait_finish(1'b0);
    chk("t2_nreads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("t2_addr0", addr_log[0], 32'h7fe);
      chk("t2_addr1", addr_log[1], 32'h7ff);
      chk("t2_addr2", addr_log[2], 32'h000);
      chk("t2_addr3", addr_log[3], 32'h001);
    end
    chk("t2_checksum", checksum, 32'd4094);

    // Back-pressure 1,0,0,1 with an ignored mid-transfer start; words 16..31 sum to 376.
    ready_mode = 1;
    begin_xfer(16, 16);
    wait_finish(1'b1);
    chk("t3_words", popped, 16);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_checksum", checksum, 32'd376);
    base_addr = '0;
    length = '0;
    ready_mode = 0;

    // Zero-length transfer.
    begin_xfer(5, 0);
    wait_finish(1'b0);
    chk("t4_done_cycle", done_rel, 1);
    chk("t4_no_reads", first_en, -1);
    chk("t4_checksum", checksum, '0);

    // Full memory of all-ones: 2048 * 0xFFFFFFFF mod 2^32.
    for (int i = 0; i < NW; i++) mem[i] = 32'hFFFF_FFFF;
    begin_xfer(0, 2048);
    wait_finish(1'b0);
    chk("t5_checksum", checksum, 32'hFFFF_F800);
    chk("t5_done_cycle", done_rel, 2051);

    // Asynchronous reset at word 100 of a second full run.
    begin_xfer(0, 2048);
    for (int i = 0; i < 400 && popped < 100; i++) @(negedge clk);
    chk("t6_reached_word100", popped >= 100, 1'b1);
    #1;
    rst = 1'b0;
    active = 1'b0;
    #1;
    chk_all_zero("t6_async");
    @(negedge clk);
    chk_all_zero("t6_held");
    #1;
    rst = 1'b1;

    // Normal transfer after reset: 0x100+0x101+0x102.
    for (int i = 0; i < NW; i++) mem[i] = DW'(i);
    begin_xfer(11'h100, 3);
    wait_finish(1'b0);
    chk("t7_checksum", checksum, 32'h303);
    chk("t7_done_cycle", done_rel, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

PL-side reader for the 2048 x 32-bit block memory shared with the Zynq PS. On a start command it reads a contiguous window of words through BRAM port B and presents them on a valid/ready stream with a last marker. It accumulates a 32-bit additive checksum and pulses done when the final word has been accepted. It is the consumer counterpart to the PL writer: the PS deposits data over port A, and this block drains it into the fabric.

## Interface
- `ADDR_W`, 11, BRAM word-address width (2^ADDR_W words)
- `DATA_W`, 32, BRAM / stream data width
- `clk`  in  1  single clock; BRAM port B also runs on `clk`
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a transfer; sampled only in IDLE
- `base_addr`  in  ADDR_W  first word address; sampled with `start`
- `length`  in  ADDR_W+1  word count, 0..2048; sampled with `start`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive
- `done`  out  1  one-cycle completion pulse
- `checksum`  out  DATA_W  sum mod 2^DATA_W of all words handshaked in the current/last transfer
- `bram_en`  out  1  port B enable (read strobe)
- `bram_addr`  out  ADDR_W  port B word address
- `bram_dout`  in  DATA_W  port B read data, valid 1 cycle after `bram_en`
- `m_data`  out  DATA_W  stream data
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready
- `m_last`  out  1  marks the final word of the transfer

## Operation
- Port B is read-only here: web is tied 0 outside this block; no write port exists.
- States:
  - IDLE -> RUN on `start` with `length`!=0.
  - IDLE -> DONE on `start` with `length`==0.
  - RUN -> DRAIN after the last read is issued.
  - DRAIN -> DONE when the last word handshakes.
  - DONE -> IDLE unconditionally after one cycle.
- `start` in any state other than IDLE is ignored; the latched `base_addr`/`length` do not change.
- Read address for word i is `(base_addr + i) mod 2^ADDR_W`: 0x7ff wraps to 0x000.
- Buffering:
  - Output is a 2-entry FIFO; FIFO head drives `m_data`.
  - A read issues in a cycle only if (FIFO occupancy + reads in flight − pop this cycle) < 2. No word is ever dropped or duplicated under any `m_ready` pattern.
- `m_last` is high exactly while the FIFO head is word `length`−1.
- `checksum`:
  - Cleared to 0 when `start` is accepted.
  - Adds `m_data` on every `m_valid`&&`m_ready`; carry discarded.
  - Holds its value after `done` until the next accepted `start`.
- `bram_en` is asserted only for issued reads; `bram_addr` holds its last value otherwise.
- Reset is asynchronous and clears all registers.
  - An in-flight read is discarded; the FIFO empties.
  - State returns to IDLE.
- Reset values: `busy`=0, `done`=0, `checksum`=0, `bram_en`=0, `bram_addr`=0, `m_data`=0, `m_valid`=0, `m_last`=0.

## Timing
- `start` is sampled at edge E0.
  - `busy`=1 and the first `bram_en` with `bram_addr`=`base_addr` appear in cycle 1.
  - `bram_dout` is valid in cycle 2 and captured at E2.
  - `m_valid`=1 first in cycle 3.
- With `m_ready` held high, one word transfers per cycle. A transfer of N words (N≥1) shows `m_valid` in cycles 3..N+2, and `done` in cycle N+3.
- `done` is asserted in the cycle after the handshake of the `m_last` word; `busy` drops with `done` in the following cycle.
- For `length`=0: `done`=1 in cycle 1, `busy`=1 in cycle 1 only, no `bram_en`, `checksum`=0.
- `m_data`/`m_last` are stable while `m_valid`&&!`m_ready`.
- The next `start` is accepted the cycle after `done`, in IDLE.

## Test plan
- BRAM preloaded mem[i]=i, `base_addr`=0, `length`=4, `m_ready`=1 -> `bram_en` in cycles 1–4 at addresses 0..3; data 0,1,2,3 in cycles 3–6 with `m_last` on 3; `done` in cycle 7; `checksum`=6.
- mem[i]=i, `base_addr`=0x7fe, `length`=4 -> addresses 0x7fe, 0x7ff, 0x000, 0x001; data 2046, 2047, 0, 1; `checksum`=4094.
- `length`=16 with `m_ready` toggling 1,0,0,1 repeating -> all 16 words in order, none lost or duplicated; occupancy never exceeds 2; `m_data` stable while stalled.
- `length`=0 -> `done` pulse in cycle 1, `bram_en` never asserted, `checksum`=0. Also: `start` pulsed again mid-transfer is ignored.
- mem all 0xFFFFFFFF, `length`=2048 -> `checksum`=0xFFFFF800; `rst` asserted at word 100 of a second run -> all outputs 0 immediately, IDLE, and a following `start` completes normally.
